// File: rtl/twiddle_gen_param_pkg.sv
// Shared FFT definitions: stage-phase encoding, the real constant used for table
// generation, and an elaboration-time log2 helper.
package fft_pkg;

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_BFLY = 2'd1;
   localparam logic [1:0] ST_TWID = 2'd2;

   typedef enum logic [1:0] {
      PH_FILL = ST_FILL,
      PH_BFLY = ST_BFLY,
      PH_TWID = ST_TWID
   } phase_e;

   localparam real PI = 3.14159265358979323846;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < value) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/twiddle_gen_param_if.sv
// Stage-control bus between the twiddle generator (slave) and whoever feeds the
// stage samples and consumes the twiddle/mux control (master).
interface twiddle_gen_param_if #(
   parameter int W = 24
) ();

   logic         in_valid;
   logic         clear;
   logic         inverse;
   logic [W-1:0] w_r;
   logic [W-1:0] w_i;
   logic [1:0]   state;
   logic         w_valid;
   logic         frame_done;

   modport master (
      output in_valid, clear, inverse,
      input  w_r, w_i, state, w_valid, frame_done
   );

   modport slave (
      input  in_valid, clear, inverse,
      output w_r, w_i, state, w_valid, frame_done
   );

endinterface

// File: rtl/twiddle_gen_param_rom.sv
// Quarter-wave cosine table C[m] = round(2**FRAC * cos(pi*m/STAGE_LEN)), m = 0..STAGE_LEN/2,
// built at elaboration; two combinational read ports serve the real and imaginary parts.
module twiddle_quarter_rom
   import fft_pkg::*;
#(
   parameter int STAGE_LEN = 128,
   parameter int W         = 24,
   parameter int FRAC      = 8
) (
   input  logic [clog2(STAGE_LEN)-1:0] addr_a,
   input  logic [clog2(STAGE_LEN)-1:0] addr_b,
   output logic [W-1:0]                c_a,
   output logic [W-1:0]                c_b
);

   localparam int  HALF  = STAGE_LEN / 2;
   localparam real SCALE = real'(64'sd1 << FRAC);

   logic [W-1:0] table_s [STAGE_LEN];

   // Entries above HALF are never addressed; they are padded so every index is defined.
   for (genvar m = 0; m < STAGE_LEN; m++) begin : g_tab
      if (m <= HALF) begin : g_live
         localparam real SCALED = SCALE * $cos(PI * m / STAGE_LEN);
         localparam int  CV     = int'($floor(SCALED + 0.5));
         assign table_s[m] = W'(CV);
      end else begin : g_pad
         assign table_s[m] = '0;
      end
   end

   assign c_a = table_s[addr_a];
   assign c_b = table_s[addr_b];

endmodule

// File: rtl/twiddle_gen_param.sv
// Twiddle generator for one radix-2 SDF stage: sequences FILL/BFLY/TWID per accepted
// sample and emits exp(-j*pi*k/STAGE_LEN), or its conjugate, one cycle later.
module twiddle_gen_param
   import fft_pkg::*;
#(
   parameter int STAGE_LEN = 128,
   parameter int W         = 24,
   parameter int FRAC      = 8
) (
   input logic                clk,
   input logic                rst,
   twiddle_gen_param_if.slave bus
);

   localparam int             AW     = clog2(STAGE_LEN);
   localparam int             PW     = AW + 1;
   localparam logic [AW:0]    FILL_N = (AW + 1)'(STAGE_LEN);
   localparam logic [AW-1:0]  HALF_A = AW'(STAGE_LEN / 2);
   localparam logic [W-1:0]   ONE    = W'(1) << FRAC;

   logic          srst_s;
   logic [AW:0]   fill_cnt_r, fill_cnt_nxt_s;
   logic [PW-1:0] ph_cnt_r, ph_cnt_nxt_s;
   logic          inv_q_r, inv_q_nxt_s;
   phase_e        phase_s;
   logic [AW-1:0] k_s;
   logic [AW-1:0] addr_a_s, addr_b_s;
   logic [W-1:0]  c_a_s, c_b_s;
   logic          neg_r_s;
   logic [W-1:0]  tw_r_s, tw_i_s;
   logic          last_s;

   logic [W-1:0]  w_r_r, w_i_r;
   phase_e        state_r;
   logic          w_valid_r, frame_done_r;

   assign srst_s = rst | bus.clear;
   assign k_s    = ph_cnt_r[AW-1:0];

   // Phase decode and counter/direction next-state; nothing moves without in_valid
   always_comb begin
      fill_cnt_nxt_s = fill_cnt_r;
      ph_cnt_nxt_s   = ph_cnt_r;
      inv_q_nxt_s    = inv_q_r;
      phase_s        = PH_FILL;
      if (fill_cnt_r < FILL_N) begin
         phase_s = PH_FILL;
         if (bus.in_valid) begin
            fill_cnt_nxt_s = fill_cnt_r + (AW + 1)'(1);
            inv_q_nxt_s    = bus.inverse;
         end else begin
            fill_cnt_nxt_s = fill_cnt_r;
         end
      end else begin
         phase_s = ph_cnt_r[PW-1] ? PH_TWID : PH_BFLY;
         if (bus.in_valid) begin
            ph_cnt_nxt_s = ph_cnt_r + PW'(1);
            if (ph_cnt_r == '0) begin
               inv_q_nxt_s = bus.inverse;
            end else begin
               inv_q_nxt_s = inv_q_r;
            end
         end else begin
            ph_cnt_nxt_s = ph_cnt_r;
         end
      end
   end

   // Fold k onto the quarter-wave table. STAGE_LEN is a power of two, so L-k is just -k in AW bits.
   always_comb begin
      addr_a_s = k_s;
      addr_b_s = HALF_A - k_s;
      neg_r_s  = 1'b0;
      if (k_s <= HALF_A) begin
         addr_a_s = k_s;
         addr_b_s = HALF_A - k_s;
         neg_r_s  = 1'b0;
      end else begin
         addr_a_s = AW'(0) - k_s;
         addr_b_s = k_s - HALF_A;
         neg_r_s  = 1'b1;
      end
   end

   twiddle_quarter_rom #(
      .STAGE_LEN (STAGE_LEN),
      .W         (W),
      .FRAC      (FRAC)
   ) u_rom (
      .addr_a (addr_a_s),
      .addr_b (addr_b_s),
      .c_a    (c_a_s),
      .c_b    (c_b_s)
   );

   // Apply quadrant and transform-direction signs
   always_comb begin
      tw_r_s = c_a_s;
      tw_i_s = -c_b_s;
      if (neg_r_s) begin
         tw_r_s = -c_a_s;
      end else begin
         tw_r_s = c_a_s;
      end
      if (inv_q_r) begin
         tw_i_s = c_b_s;
      end else begin
         tw_i_s = -c_b_s;
      end
   end

   assign last_s = (phase_s == PH_TWID) && (k_s == {AW{1'b1}});

   // Frame-position counters and latched direction
   always_ff @(posedge clk) begin
      if (srst_s) begin
         fill_cnt_r <= '0;
         ph_cnt_r   <= '0;
         inv_q_r    <= 1'b0;
      end else begin
         fill_cnt_r <= fill_cnt_nxt_s;
         ph_cnt_r   <= ph_cnt_nxt_s;
         inv_q_r    <= inv_q_nxt_s;
      end
   end

   // Output registers: describe the sample accepted on the previous cycle, hold otherwise
   always_ff @(posedge clk) begin
      if (srst_s) begin
         w_r_r        <= '0;
         w_i_r        <= '0;
         state_r      <= PH_FILL;
         w_valid_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else if (bus.in_valid) begin
         w_valid_r    <= 1'b1;
         state_r      <= phase_s;
         frame_done_r <= last_s;
         if (phase_s == PH_TWID) begin
            w_r_r <= tw_r_s;
            w_i_r <= tw_i_s;
         end else begin
            w_r_r <= ONE;
            w_i_r <= '0;
         end
      end else begin
         w_valid_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end
   end

   assign bus.w_r        = w_r_r;
   assign bus.w_i        = w_i_r;
   assign bus.state      = state_r;
   assign bus.w_valid    = w_valid_r;
   assign bus.frame_done = frame_done_r;

endmodule
